// File: rtl/mem_pkg.sv
// Shared definitions for the LSU data memory: funct3 codes, ram_sel fields, FSM states
// and the lane extract/merge helpers used by lsu_data_mem.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int SEL_STORE_BIT = 0;
    localparam int SEL_F3_LSB    = 1;
    localparam int SEL_F3_MSB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic sel_legal(input logic [3:0] sel);
        logic [2:0] f3;
        logic       ok;
        f3 = sel[SEL_F3_MSB:SEL_F3_LSB];
        if (sel[SEL_STORE_BIT])
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3)
            F3_H, F3_HU: m = lo[0];
            F3_W:        m = (lo != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [2:0]  f3,
                                                 input logic [31:0] word,
                                                 input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            F3_W:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Only the addressed lane is replaced; the rest of the old word is kept.
    function automatic logic [31:0] lane_merge(input logic [2:0]  f3,
                                               input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0]  lo);
        logic [31:0] r;
        r = old;
        case (f3)
            F3_B: begin
                case (lo)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            F3_H: begin
                if (lo[1]) r[31:16] = wd[15:0];
                else       r[15:0]  = wd[15:0];
            end
            F3_W:    r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port DEPTH_WORDS x 32 synchronous SRAM: write or read per enabled edge,
// read data registered; contents are not reset.
module mem_sram_1rw #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[addr] <= wdata;
            else    rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lsu_data_mem.sv
// RV32I load/store responder over a word-wide SRAM with read-modify-write for SB/SH.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned LH/LHU/SH/LW/SW as errors.
//
// state | meaning
// IDLE  | ready; SW and errors complete from here, everything else goes to READ
// READ  | SRAM read of the latched word index
// MERGE | SRAM data valid: extract load result, or write merged word for SB/SH
// RESP  | resp_valid pulse, rdata/resp_err held
module lsu_data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        ram_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    lsu_state_e       state_q, state_d;
    logic [3:0]       sel_q;
    logic [1:0]       lo_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             ram_en, ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata, ram_rdata;

    logic [2:0]       f3_in;
    logic             store_in, err_in;
    logic             addr_hi_unused;

    assign f3_in          = ram_sel[SEL_F3_MSB:SEL_F3_LSB];
    assign store_in       = ram_sel[SEL_STORE_BIT];
    assign addr_hi_unused = ^addr[ADDR_W-1:IDX_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign err_in = !sel_legal(ram_sel) || misaligned(f3_in, addr[1:0]);
`else
    assign err_in = !sel_legal(ram_sel);
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (err_in) begin
                        state_d = ST_RESP;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (store_in && (f3_in == F3_W)) begin
                        // Full-word store needs no read, so it writes on the accept edge.
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = addr[IDX_W+1:2];
                        ram_wdata = wdata;
                        state_d   = ST_RESP;
                        rdata_d   = 32'd0;
                        err_d     = 1'b0;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                ram_en  = 1'b1;
                state_d = ST_MERGE;
            end
            ST_MERGE: begin
                state_d = ST_RESP;
                err_d   = 1'b0;
                if (sel_q[SEL_STORE_BIT]) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = lane_merge(sel_q[SEL_F3_MSB:SEL_F3_LSB], ram_rdata, wdata_q, lo_q);
                    rdata_d   = 32'd0;
                end else begin
                    rdata_d = lane_extract(sel_q[SEL_F3_MSB:SEL_F3_LSB], ram_rdata, lo_q);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 4'd0;
            lo_q    <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && req_valid) begin
            sel_q   <= ram_sel;
            lo_q    <= addr[1:0];
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
        end
    end

    mem_sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign rdata      = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Scoreboard bench for lsu_data_mem: expected responses queued at issue, popped on resp_valid.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_data_mem;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } req_t;

    localparam logic [3:0] S_LB = 4'b0000, S_LH = 4'b0010, S_LW = 4'b0100,
                           S_LBU = 4'b1000, S_LHU = 4'b1010,
                           S_SB = 4'b0001, S_SH = 4'b0011, S_SW = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  ram_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    req_t exp_q[$];
    int   acc_q[$];

    lsu_data_mem #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ram_sel   (ram_sel),
        .addr      (addr),
        .wdata     (wdata),
        .resp_valid(resp_valid),
        .rdata     (rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic req_t mk(logic [3:0] s, logic [31:0] a, logic [31:0] w,
                                logic [31:0] r, logic e, int l);
        req_t t;
        t.sel = s; t.addr = a; t.wdata = w; t.rd = r; t.err = e; t.lat = l;
        return t;
    endfunction

    task automatic issue(input req_t r);
        int w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            total++; bad++;
            $display("FAIL issue_timeout: req_ready stayed %b, required 1", req_ready);
        end
        ram_sel = r.sel; addr = r.addr; wdata = r.wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] rd, output logic er, output int lat,
                           output logic pulse_ok);
        lat = -1; rd = 'x; er = 'x;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                rd = rdata; er = resp_err; lat = n;
                break;
            end
        end
        @(negedge clk);
        pulse_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({req_ready, resp_valid, rdata, resp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                     req_ready, resp_valid, rdata, resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_list(input string name, input req_t t[$]);
        logic [31:0] rd; logic er; int lat; logic pl; req_t e;
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i]);
            collect(rd, er, lat, pl);
            e = exp_q.pop_front();
            total++;
            if ({rd, er, lat, pl} !== {e.rd, e.err, e.lat, 1'b1}) begin
                bad++;
                $display("FAIL %s[%0d]: got rdata=%h err=%b lat=%0d pulse_ok=%b, required rdata=%h err=%b lat=%0d pulse_ok=1",
                         name, i, rd, er, lat, pl, e.rd, e.err, e.lat);
            end
        end
    endtask

    task automatic test_store_load();
        req_t t[$];
        t.push_back(mk(S_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1));
        t.push_back(mk(S_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3));
        run_list("store_load", t);
    endtask

    task automatic test_subword_load();
        req_t t[$];
        t.push_back(mk(S_LB,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 3));
        t.push_back(mk(S_LBU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 3));
        t.push_back(mk(S_LH,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3));
        t.push_back(mk(S_LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3));
        run_list("subword_load", t);
    endtask

    task automatic test_subword_store();
        req_t t[$];
        t.push_back(mk(S_SB, 32'h11, 32'hAAAAAA55, 32'h0, 1'b0, 3));
        t.push_back(mk(S_LW, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 3));
        t.push_back(mk(S_SH, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3));
        t.push_back(mk(S_LW, 32'h10, 32'h0, 32'h123455EF, 1'b0, 3));
        t.push_back(mk(S_LB, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 3));
        run_list("subword_store", t);
    endtask

    task automatic test_errors();
        req_t t[$];
        t.push_back(mk(4'b0110, 32'h10, 32'h0,        32'h0, 1'b1, 1));
        t.push_back(mk(4'b1001, 32'h10, 32'h0,        32'h0, 1'b1, 1));
        t.push_back(mk(4'b1100, 32'h10, 32'h0,        32'h0, 1'b1, 1));
        t.push_back(mk(4'b1111, 32'h10, 32'h01020304, 32'h0, 1'b1, 1));
        t.push_back(mk(S_LW,    32'h10, 32'h0, 32'h123455EF, 1'b0, 3));
        run_list("errors", t);
    endtask

    task automatic test_misalign();
        req_t t[$];
`ifdef LSU_MISALIGN_TRAP_EN
        t.push_back(mk(S_LW, 32'h11, 32'h0, 32'h0, 1'b1, 1));
        t.push_back(mk(S_LH, 32'h13, 32'h0, 32'h0, 1'b1, 1));
        t.push_back(mk(S_SW, 32'h12, 32'h0BADF00D, 32'h0, 1'b1, 1));
        t.push_back(mk(S_LW, 32'h10, 32'h0, 32'h123455EF, 1'b0, 3));
`else
        t.push_back(mk(S_LW, 32'h11, 32'h0, 32'h123455EF, 1'b0, 3));
        t.push_back(mk(S_LH, 32'h13, 32'h0, 32'h00001234, 1'b0, 3));
        t.push_back(mk(S_SW, 32'h12, 32'h0BADF00D, 32'h0, 1'b0, 1));
        t.push_back(mk(S_LW, 32'h10, 32'h0, 32'h0BADF00D, 1'b0, 3));
`endif
        run_list("misalign", t);
    endtask

    task automatic test_wrap();
        req_t t[$];
        t.push_back(mk(S_SW, 32'h00001014, 32'hCAFEF00D, 32'h0, 1'b0, 1));
        t.push_back(mk(S_LW, 32'h00000014, 32'h0, 32'hCAFEF00D, 1'b0, 3));
        t.push_back(mk(S_SW, 32'h00000FFC, 32'h11112222, 32'h0, 1'b0, 1));
        t.push_back(mk(S_LW, 32'hFFFFFFFC, 32'h0, 32'h11112222, 1'b0, 3));
        run_list("wrap", t);
    endtask

    task automatic test_back_to_back();
        req_t t[$];
        int   n;
        t.push_back(mk(S_SW,  32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 1));
        t.push_back(mk(S_LW,  32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 3));
        t.push_back(mk(S_SB,  32'h22, 32'h0000003C, 32'h0, 1'b0, 3));
        t.push_back(mk(S_LW,  32'h20, 32'h0, 32'hA53CA5A5, 1'b0, 3));
        t.push_back(mk(S_LBU, 32'h22, 32'h0, 32'h0000003C, 1'b0, 3));
        n = t.size();
        fork
            begin
                int prev_acc = 0;
                for (int i = 0; i < n; i++) begin
                    int w = 0;
                    @(negedge clk);
                    ram_sel = t[i].sel; addr = t[i].addr; wdata = t[i].wdata; req_valid = 1'b1;
                    while (req_ready !== 1'b1 && w < 20) begin
                        @(negedge clk);
                        w++;
                    end
                    if (i > 0) begin
                        total++;
                        if (cyc - prev_acc !== t[i-1].lat + 1) begin
                            bad++;
                            $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d",
                                     i, cyc - prev_acc, t[i-1].lat + 1);
                        end
                    end
                    prev_acc = cyc;
                    exp_q.push_back(t[i]);
                    acc_q.push_back(cyc);
                    @(posedge clk);
                end
                #1 req_valid = 1'b0;
            end
            begin
                int got = 0;
                req_t e;
                int a;
                for (int k = 0; k < 80 && got < n; k++) begin
                    @(negedge clk);
                    if (resp_valid === 1'b1 && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        got++;
                        total++;
                        if ({rdata, resp_err, cyc - a} !== {e.rd, e.err, e.lat}) begin
                            bad++;
                            $display("FAIL b2b_resp[%0d]: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                                     got - 1, rdata, resp_err, cyc - a, e.rd, e.err, e.lat);
                        end
                    end
                end
                if (got < n) begin
                    total++; bad++;
                    $display("FAIL b2b_timeout: got %0d responses, required %0d", got, n);
                end
            end
        join
    endtask

    task automatic test_reset_midop();
        req_t sb;
        req_t t[$];
        sb = mk(S_SB, 32'h20, 32'h00000011, 32'h0, 1'b0, 3);
        for (int phase = 0; phase < 3; phase++) begin
            issue(sb);
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_ready[%0d]: got %b, required 0", phase, req_ready);
            end
            for (int k = 0; k < phase; k++) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({req_ready, resp_valid, rdata, resp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset_midop[%0d]: got ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                         phase, req_ready, resp_valid, rdata, resp_err);
            end
            @(negedge clk);
            rst_n = 1'b1;
            t.delete();
            t.push_back(mk(S_LW, 32'h20, 32'h0, (phase == 2) ? 32'hA53CA511 : 32'hA53CA5A5, 1'b0, 3));
            run_list("reset_midop_readback", t);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; ram_sel = 4'd0; addr = 32'd0; wdata = 32'd0;
        test_reset();
        test_store_load();
        test_subword_load();
        test_subword_store();
        test_errors();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
